sm_spi_framebuffer_responder: RTL

SPI responder that emulates a byte-addressed serial SRAM in front of the matrix framebuffer, so the display-side SPI reader and an external host can both reach frame data. It decodes mode-0 SPI frames, oversampled on `clk_50`: a command byte, a 16-bit address, then streamed data bytes. Writes go to a synchronous framebuffer RAM port; reads return RAM bytes MSB-first on `spi_so`.

---
 rtl/sm_spi_framebuffer_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sm_spi_framebuffer_responder.sv
// SPI mode-0 responder that looks like a byte-addressed serial SRAM.
// Frames: command byte (0x02 write, 0x03 read), 16-bit address, data bytes.
// All SPI pins are oversampled on clk_50 and the framebuffer RAM is
// reached through a synchronous port with one cycle of read latency.
module sm_spi_framebuffer_responder #(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_si,
  output logic              spi_so,
  output logic              spi_so_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err_cmd
);

  // Wide enough for a command byte and for the kept address bits; the
  // address bits above ADDR_W simply fall off the top of the shifter.
  localparam int SHIFT_W = (ADDR_W > 8) ? ADDR_W : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, si_sync;
  logic                   sck_d;
  logic                   cs_s, sck_s, si_s;
  logic                   sck_rise, sck_fall;

  logic [SHIFT_W-2:0]     shift_in;
  logic [SHIFT_W-1:0]     in_word;
  logic [3:0]             bit_cnt;
  logic [ADDR_W-1:0]      ptr;
  logic                   is_read;
  logic [7:0]             so_sr;
  logic                   rd_req, rd_load;

  logic                   abort;
  logic                   cmd_done, cmd_ok, addr_done, byte_done;

  // Input synchronizers and the delayed SCK used for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the chain.
  // The CS chain resets to 1 so reset release never looks like a select.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      si_sync  <= '0;
      sck_d    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      si_sync  <= {si_sync[SYNC_STAGES-2:0], spi_si};
      sck_d    <= sck_s;
    end
  end

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign si_s  = si_sync[SYNC_STAGES-1];

  // Edges seen while deselected are dropped, so CS rising beats SCK rising.
  assign sck_rise = sck_s & ~sck_d & ~cs_s;
  assign sck_fall = ~sck_s & sck_d & ~cs_s;

  // State register.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (!cs_s) state_nx = S_CMD;
        S_CMD:    if (cmd_done) state_nx = cmd_ok ? S_ADDR : S_IGNORE;
        S_ADDR:   if (addr_done) state_nx = is_read ? S_RDATA : S_WDATA;
        S_WDATA:  state_nx = S_WDATA;
        S_RDATA:  state_nx = S_RDATA;
        S_IGNORE: state_nx = S_IGNORE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Output and strobe decode from the current state and edge pulses.
  // NOTE: every always_comb target gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    busy      = (state != S_IDLE);
    abort     = (state != S_IDLE) && cs_s;
    in_word   = {shift_in, si_s};
    cmd_ok    = (in_word[7:0] == 8'h02) || (in_word[7:0] == 8'h03);
    cmd_done  = (state == S_CMD) && sck_rise && (bit_cnt == 4'd7);
    addr_done = (state == S_ADDR) && sck_rise && (bit_cnt == 4'd15);
    byte_done = ((state == S_WDATA) || (state == S_RDATA)) && sck_rise &&
                (bit_cnt == 4'd7);
  end

  // Datapath: bit shifting, pointer, RAM port and serial output.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      shift_in  <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      is_read   <= 1'b0;
      so_sr     <= '0;
      rd_req    <= 1'b0;
      rd_load   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      err_cmd   <= 1'b0;
      spi_so    <= 1'b0;
      spi_so_en <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      err_cmd <= 1'b0;
      rd_req  <= 1'b0;
      rd_load <= rd_req;

      if (abort) begin
        // Deselect kills any partial byte and any read in flight.
        spi_so    <= 1'b0;
        spi_so_en <= 1'b0;
        rd_req    <= 1'b0;
        rd_load   <= 1'b0;
      end else begin
        if ((state == S_IDLE) && !cs_s) begin
          bit_cnt  <= '0;
          shift_in <= '0;
        end

        if (sck_rise && (state inside {S_CMD, S_ADDR, S_WDATA, S_RDATA})) begin
          shift_in <= in_word[SHIFT_W-2:0];
          bit_cnt  <= bit_cnt + 4'd1;
        end

        if (cmd_done) begin
          bit_cnt <= '0;
          is_read <= (in_word[7:0] == 8'h03);
          err_cmd <= !cmd_ok;
        end

        if (addr_done) begin
          bit_cnt <= '0;
          ptr     <= in_word[ADDR_W-1:0];
          if (is_read) begin
            mem_addr <= in_word[ADDR_W-1:0];
            rd_req   <= 1'b1;
          end
        end

        if (byte_done) begin
          bit_cnt <= '0;
          ptr     <= ptr + ADDR_W'(1);
          if (state == S_WDATA) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= in_word[7:0];
          end else begin
            mem_addr <= ptr + ADDR_W'(1);
            rd_req   <= 1'b1;
          end
        end

        // RAM data is valid the cycle after the address flop settles.
        if (rd_load) so_sr <= mem_rdata;

        if (sck_fall && (state == S_RDATA)) begin
          spi_so    <= so_sr[7];
          spi_so_en <= 1'b1;
          so_sr     <= {so_sr[6:0], 1'b0};
        end
      end
    end
  end

endmodule
